// File: rtl/sample_48_packer.sv
// rtl/sample_48_packer.sv - packs an 8-bit byte stream MSB-first into signed samples with a FWFT output queue
// Optional idle timeout on partial samples: define PACKER_TIMEOUT_EN.
module sample_48_packer #(
    parameter int NBYTES  = 6,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024,
    localparam int SW = 8 * NBYTES,
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 sync_clr,
    input  logic [7:0]           byte_in,
    input  logic                 byte_valid,
    output logic                 byte_ready,
    output logic signed [SW-1:0] sample_out,
    output logic                 sample_valid,
    input  logic                 sample_ready,
    output logic [LW-1:0]        fifo_level,
    output logic                 frame_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 2 || NBYTES < 2) begin : g_bad_param
            $error("sample_48_packer: illegal parameter set");
        end
    endgenerate

    logic [IW-1:0] idx_q, idx_d;
    logic [SW-1:0] asm_q, asm_d;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q;
    logic [SW-1:0] mem_q [DEPTH];

    logic full, pop, accept, last_byte, push, timeout;

    assign full         = (level_q == LW'(DEPTH));
    assign sample_valid = (level_q != '0);
    assign pop          = sample_valid & sample_ready;
    assign last_byte    = (idx_q == LAST_IDX);
    // The final byte may enter a full queue only when a pop frees a slot this cycle.
    assign byte_ready   = !last_byte || !full || pop;
    assign accept       = byte_valid & byte_ready;
    assign push         = accept & last_byte & !sync_clr;

    assign fifo_level   = level_q;
    assign sample_out   = sample_valid ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        idx_d = idx_q;
        asm_d = asm_q;
        if (sync_clr || timeout) begin
            idx_d = '0;
            asm_d = '0;
        end else if (accept) begin
            if (last_byte) begin
                idx_d = '0;
                asm_d = '0;
            end else begin
                idx_d = idx_q + 1'b1;
                for (int k = 0; k < NBYTES; k++) begin
                    if (idx_q == IW'(k)) begin
                        asm_d[SW-1-8*k -: 8] = byte_in;
                    end
                end
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            idx_q    <= '0;
            asm_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            idx_q <= idx_d;
            asm_q <= asm_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage needs no reset: the empty gate on sample_out hides stale entries.
    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {asm_q[SW-1:8], byte_in};
        end
    end

`ifdef PACKER_TIMEOUT_EN
    logic [15:0] idle_q;
    logic        frame_err_q;

    assign timeout   = !sync_clr && !accept && (idx_q != '0) && (idle_q == 16'(TIMEOUT - 1));
    assign frame_err = frame_err_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            idle_q      <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= timeout;
            if (sync_clr || accept || (idx_q == '0) || timeout) begin
                idle_q <= '0;
            end else begin
                idle_q <= idle_q + 16'd1;
            end
        end
    end
`else
    assign timeout   = 1'b0;
    assign frame_err = 1'b0;
`endif

endmodule
